// File: rtl/shift_pkg.sv
// Shared constants and the decoded-entry type for the shift issue stage.
// Opcode/funct encodings cover the RV32I/RV64I register and immediate shift forms.
package shift_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int unsigned AMT_W = 6;
  localparam int unsigned RD_W  = 5;

  // One decoded shift: amount, direction, arithmetic flag, destination.
  typedef struct packed {
    logic [AMT_W-1:0] amt;
    logic             f3_2;
    logic             f7_5;
    logic [RD_W-1:0]  rd;
  } dec_entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of SLL/SRL/SRA/SLLI/SRLI/SRAI.
// Ports:
//   instr     in   32    instruction word
//   rs2_data  in   XLEN  rs2 operand, source of the R-type shift amount
//   legal     out  1     instruction is a legal shift for this XLEN
//   entry     out        decoded {amt, f3_2, f7_5, rd}; amt bit5 is 0 when XLEN = 32
module shift_decode
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs2_data,
  output logic            legal,
  output dec_entry_t      entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f3_ok;
  logic       r_hi_ok;
  logic       i_hi_ok;

  // Operand bits that only some encodings or widths consume.
  logic unused_bits;
  assign unused_bits = ^{instr, rs2_data};

  always_comb begin
    opcode  = instr[6:0];
    funct3  = instr[14:12];
    funct7  = instr[31:25];
    f3_ok   = (funct3 == F3_SLL) || (funct3 == F3_SR);
    // SRA/SRAI only exist with funct3 = 101.
    r_hi_ok = (funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == F3_SR));
    if (XLEN == 64) begin
      // RV64 immediate shifts borrow instr[25] as shamt bit 5.
      i_hi_ok = (instr[31:26] == F7_BASE[6:1]) ||
                ((instr[31:26] == F7_ALT[6:1]) && (funct3 == F3_SR));
    end else begin
      // RV32: instr[25] = 1 is a reserved encoding and fails this check.
      i_hi_ok = r_hi_ok;
    end

    legal      = 1'b0;
    entry      = '0;
    entry.rd   = instr[11:7];
    entry.f3_2 = funct3[2];
    entry.f7_5 = instr[30];

    if (opcode == OPC_OP) begin
      legal     = f3_ok & r_hi_ok;
      entry.amt = (XLEN == 64) ? rs2_data[5:0] : {1'b0, rs2_data[4:0]};
    end else if (opcode == OPC_OPIMM) begin
      legal     = f3_ok & i_hi_ok;
      entry.amt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes shift instructions into a D register that drives an
// external combinational shift unit, then captures its result into a W register
// for regfile writeback. Two-entry valid/ready pipeline, illegal-opcode pulse.
// Ports:
//   CLK, rst (sync, active-high), flush (sync kill of D and W)
//   in_valid/in_ready, Instr, Rs1_data, Rs2_data   : issue side
//   Src1, Src2, funct3_2, funct7_5, En, Result      : shift unit interface
//   wb_valid/wb_ready, wb_rd, wb_data               : writeback side
//   Illegal                                         : 1-cycle pulse for a rejected instr
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] Rs1_data,
  input  logic [XLEN-1:0] Rs2_data,
  output logic [XLEN-1:0] Src1,
  output logic [5:0]      Src2,
  output logic            funct3_2,
  output logic            funct7_5,
  output logic            En,
  input  logic [XLEN-1:0] Result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            Illegal
);

  logic       dec_legal;
  dec_entry_t dec_entry;

  shift_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr    (Instr),
    .rs2_data (Rs2_data),
    .legal    (dec_legal),
    .entry    (dec_entry)
  );

  logic            d_valid_q, d_valid_d;
  dec_entry_t      d_entry_q, d_entry_d;
  logic [XLEN-1:0] d_src1_q,  d_src1_d;
  logic            w_valid_q, w_valid_d;
  logic [4:0]      w_rd_q,    w_rd_d;
  logic [XLEN-1:0] w_data_q,  w_data_d;
  logic            illegal_q, illegal_d;
  logic            adv_d;
  logic            accept;
  logic            load_d;

  always_comb begin
    adv_d    = d_valid_q & (~w_valid_q | wb_ready);
    in_ready = ~d_valid_q | adv_d;
    accept   = in_valid & in_ready & ~flush;
    // Writes to x0 are accepted but discarded here.
    load_d   = accept & dec_legal & (dec_entry.rd != '0);

    d_valid_d = d_valid_q;
    d_entry_d = d_entry_q;
    d_src1_d  = d_src1_q;
    if (load_d) begin
      d_valid_d = 1'b1;
      d_entry_d = dec_entry;
      d_src1_d  = Rs1_data;
    end else if (adv_d) begin
      d_valid_d = 1'b0;
    end

    w_valid_d = w_valid_q;
    w_rd_d    = w_rd_q;
    w_data_d  = w_data_q;
    if (adv_d) begin
      w_valid_d = 1'b1;
      w_rd_d    = d_entry_q.rd;
      w_data_d  = Result;
    end else if (wb_ready) begin
      w_valid_d = 1'b0;
    end

    // Flush wins over both the load and the writeback handshake.
    if (flush) begin
      d_valid_d = 1'b0;
      w_valid_d = 1'b0;
    end

    illegal_d = accept & ~dec_legal;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      d_valid_q <= 1'b0;
      d_entry_q <= '0;
      d_src1_q  <= '0;
      w_valid_q <= 1'b0;
      w_rd_q    <= '0;
      w_data_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      d_valid_q <= d_valid_d;
      d_entry_q <= d_entry_d;
      d_src1_q  <= d_src1_d;
      w_valid_q <= w_valid_d;
      w_rd_q    <= w_rd_d;
      w_data_q  <= w_data_d;
      illegal_q <= illegal_d;
    end
  end

  // Shift unit and writeback fields read as zero while their entry is empty.
  always_comb begin
    En       = d_valid_q;
    Src1     = d_valid_q ? d_src1_q : '0;
    Src2     = d_valid_q ? d_entry_q.amt : '0;
    funct3_2 = d_valid_q & d_entry_q.f3_2;
    funct7_5 = d_valid_q & d_entry_q.f7_5;
    wb_valid = w_valid_q;
    wb_rd    = w_valid_q ? w_rd_q : '0;
    wb_data  = w_valid_q ? w_data_q : '0;
    Illegal  = illegal_q;
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  logic        CLK = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] Instr, Rs1_data, Rs2_data, Src1, Result, wb_data;
  logic [5:0]  Src2;
  logic        funct3_2, funct7_5, En, wb_valid, wb_ready, Illegal;
  logic [4:0]  wb_rd;

  always #5 CLK = ~CLK;

  shift_issue_stage #(.XLEN(32)) dut (
    .CLK(CLK), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .Rs1_data(Rs1_data), .Rs2_data(Rs2_data), .Src1(Src1), .Src2(Src2),
    .funct3_2(funct3_2), .funct7_5(funct7_5), .En(En), .Result(Result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .Illegal(Illegal)
  );

  // Model of the external combinational shift unit.
  logic signed [31:0] sra_r;
  assign sra_r  = $signed(Src1) >>> Src2;
  assign Result = !funct3_2 ? (Src1 << Src2) : (funct7_5 ? sra_r : (Src1 >> Src2));

  int total = 0;
  int bad = 0;
  int exp_ill = 0;
  int obs_ill = 0;
  int wb_seen = 0;
  int n_acc = 0;
  logic [36:0] sb[$];   // {rd, data} expected writebacks in order

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [31:0] ins);
    case ({ins[31:25], ins[14:12], ins[6:0]})
      {7'b0000000, 3'b001, 7'b0110011}, {7'b0000000, 3'b101, 7'b0110011},
      {7'b0100000, 3'b101, 7'b0110011}, {7'b0000000, 3'b001, 7'b0010011},
      {7'b0000000, 3'b101, 7'b0010011}, {7'b0100000, 3'b101, 7'b0010011}: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] s;
    if (ins[6:0] == 7'b0110011) sh = b % 32;
    else sh = int'(ins[24:20]);
    if (ins[14:12] == 3'b001) return a << sh;
    if (ins[30]) begin
      s = $signed(a) >>> sh;
      return s;
    end
    return a >> sh;
  endfunction

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic wr, input logic rs,
                      output logic acc);
    in_valid = v; Instr = ins; Rs1_data = a; Rs2_data = b;
    flush = fl; wb_ready = wr; rst = rs;
    @(negedge CLK);
    acc = v && in_ready && !fl && !rs;
    if (fl || rs) sb.delete();
    if (acc) begin
      n_acc++;
      if (!ref_legal(ins)) exp_ill++;
      else if (ins[11:7] != 5'd0) sb.push_back({ins[11:7], ref_shift(ins, a, b)});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic wr);
    logic acc;
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, wr, 1'b0, acc);
  endtask

  // Monitor: pops on a writeback handshake, otherwise checks the held head entry.
  always @(negedge CLK) begin
    if (Illegal) obs_ill++;
    if (!rst && !flush && wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {wb_rd, wb_data}, 37'h0);
      end else if (wb_ready) begin
        chk("wb_entry", {wb_rd, wb_data}, sb.pop_front());
        wb_seen++;
      end else begin
        chk("wb_hold", {wb_rd, wb_data}, sb[0]);
      end
    end
  end

  localparam logic [31:0] I_SLL  = 32'h002092B3;
  localparam logic [31:0] I_SRAI = 32'h4030D313;
  localparam logic [31:0] I_SRL  = 32'h0020D3B3;
  localparam logic [31:0] I_ADD  = 32'h002082B3;
  localparam logic [31:0] I_SLLI25 = 32'h02309293;

  function automatic logic [31:0] mk(input int t, input logic [4:0] rd);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] r2;
    logic [4:0] r1;
    opc = (t < 3) ? 7'b0110011 : 7'b0010011;
    f3  = (t % 3 == 0) ? 3'b001 : 3'b101;
    f7  = (t % 3 == 2) ? 7'b0100000 : 7'b0000000;
    r2  = 5'($urandom);
    r1  = 5'($urandom);
    return {f7, r2, r1, f3, rd, opc};
  endfunction

  initial begin
    logic acc;
    int idx;
    int w0;
    logic [4:0] hits;
    logic [31:0] bp_ins[3];
    logic [31:0] bp_a[3];
    logic [31:0] bp_b[3];
    logic [31:0] ins;

    in_valid = 0; Instr = 0; Rs1_data = 0; Rs2_data = 0;
    flush = 0; wb_ready = 0; rst = 1;
    repeat (2) @(posedge CLK);
    #1;
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_en", En, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_src1", Src1, 0);
    chk("rst_wb_data", wb_data, 0);

    // SLL x5 = 50 << 4
    step(1'b1, I_SLL, 32'd50, 32'd4, 1'b0, 1'b1, 1'b0, acc);
    chk("sll_acc", acc, 1);
    chk("sll_en", En, 1);
    chk("sll_src2", Src2, 6'd4);
    chk("sll_f3", funct3_2, 0);
    idle(1'b1);
    chk("sll_wbv", wb_valid, 1);
    chk("sll_rd", wb_rd, 5);
    chk("sll_data", wb_data, 32'h320);

    // SRAI x6 = ABCDFFFF >>> 3
    step(1'b1, I_SRAI, 32'hABCDFFFF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
    chk("srai_f3", funct3_2, 1);
    chk("srai_f7", funct7_5, 1);
    idle(1'b1);
    chk("srai_data", wb_data, 32'hF579BFFF);
    idle(1'b1);

    // Three back-to-back SRLs: writebacks on three consecutive cycles.
    hits = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, I_SRL, 32'hABCDFFFF, 32'd5, 1'b0, 1'b1, 1'b0, acc);
      else idle(1'b1);
      hits[i] = wb_valid && (wb_data == 32'h055E6FFF);
    end
    chk("srl_b2b", hits, 5'b01110);

    // Backpressure: 4 stalled cycles, three instructions offered.
    for (int i = 0; i < 3; i++) begin
      bp_ins[i] = mk(i, 5'(8 + i));
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, bp_ins[idx], bp_a[idx], bp_b[idx], 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_w_data", wb_data, ref_shift(bp_ins[0], bp_a[0], bp_b[0]));
    chk("bp_d_src1", Src1, bp_a[1]);
    chk("bp_d_src2", Src2, {1'b0, bp_b[1][4:0]});
    w0 = wb_seen;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      step(1'b1, bp_ins[idx], bp_a[idx], bp_b[idx], 1'b0, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_third_acc", idx, 3);
    repeat (4) idle(1'b1);
    chk("bp_drain", wb_seen - w0, 3);

    // Illegal encodings: one pulse each, no writeback.
    w0 = wb_seen;
    idx = exp_ill;
    step(1'b1, I_ADD, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, acc);
    chk("add_illegal", Illegal, 1);
    step(1'b1, I_SLLI25, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, acc);
    chk("slli25_illegal", Illegal, 1);
    idle(1'b1);
    chk("illegal_clear", Illegal, 0);
    repeat (2) idle(1'b1);
    chk("illegal_cnt", exp_ill - idx, 2);
    chk("illegal_obs", obs_ill, exp_ill);
    chk("illegal_no_wb", wb_seen - w0, 0);

    // Flush with D and W full and a same-cycle input.
    step(1'b1, mk(0, 5'd11), 32'h1234, 32'd3, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, mk(1, 5'd12), 32'h5678, 32'd2, 1'b0, 1'b0, 1'b0, acc);
    chk("fl_full", {wb_valid, En, in_ready}, 3'b110);
    w0 = wb_seen;
    step(1'b1, mk(2, 5'd13), 32'h9abc, 32'd1, 1'b1, 1'b0, 1'b0, acc);
    chk("fl_wbv", wb_valid, 0);
    chk("fl_en", En, 0);
    chk("fl_in_ready", in_ready, 1);
    repeat (3) idle(1'b1);
    chk("fl_no_wb", wb_seen - w0, 0);

    // Randomized traffic with backpressure, flush and reset.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: ins = mk($urandom_range(0, 5), 5'($urandom));
        5: ins = {7'b0, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0110011};
        6: ins = $urandom;
        default: ins = {7'b0000001, 5'($urandom), 5'($urandom), 3'b001, 5'($urandom),
                        7'b0010011};
      endcase
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0, acc);
    end
    for (int c = 0; c < 30 && sb.size() != 0; c++) idle(1'b1);
    idle(1'b1);
    chk("final_drain", sb.size(), 0);
    chk("final_illegal", obs_ill, exp_ill);
    chk("final_acc_nonzero", n_acc > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
